f1_start_ctrl: RTL and testbench

Race-start sequencer for the F1 light bar. Owns the tick timebase (clock divided by N+1), steps the eight start lights on, holds them lit for a pseudo-random number of ticks, and switches them off. It then measures the driver's reaction time in clock cycles and flags a false start if `react` arrives before lights-out. It sits between the push-button inputs and the 8-bit light output, replacing the free-running light generator with a triggered, single-shot sequence.

---
 rtl/f1_start_ctrl_if.sv | 25 ++
 rtl/f1_start_ctrl.sv | 133 +++++++++++++
 tb/tb_f1_start_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/f1_start_ctrl_if.sv
// Handshake bundle between the start-light sequencer and its surroundings:
// button/enable/period inputs on one side, light bar and latched result on the other.
interface f1_start_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             trigger;
    logic             react;
    logic [CNT_W-1:0] N;
    logic [7:0]       data_out;
    logic             busy;
    logic             done;
    logic             false_start;
    logic [CNT_W-1:0] react_time;

    modport master (
        output en, trigger, react, N,
        input  data_out, busy, done, false_start, react_time
    );

    modport slave (
        input  en, trigger, react, N,
        output data_out, busy, done, false_start, react_time
    );
endinterface

// File: rtl/f1_start_ctrl.sv
// Single-shot F1 start sequencer: steps eight lights on a divided tick, holds for a
// pseudo-random number of ticks, goes dark and times the driver's reaction.
module f1_start_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    f1_start_ctrl_if.slave ctrl
);
    typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, TIMING} state_t;

    state_t           state, state_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             done_q, done_nxt;
    logic             fs_q, fs_nxt;
    logic [CNT_W-1:0] rt_q, rt_nxt;
    logic [6:0]       lfsr, lfsr_nxt;
    logic [CNT_W-1:0] div, div_nxt;
    logic [6:0]       hold_cnt, hold_nxt;
    logic [CNT_W-1:0] rcnt, rcnt_nxt;
    logic             tick;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign tick = (div == '0) && ctrl.en && (state != IDLE);

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        done_nxt  = done_q;
        fs_nxt    = fs_q;
        rt_nxt    = rt_q;
        lfsr_nxt  = lfsr;
        div_nxt   = div;
        hold_nxt  = hold_cnt;
        rcnt_nxt  = rcnt;

        if (ctrl.en) begin
            done_nxt = 1'b0;
            lfsr_nxt = lfsr_step(lfsr);
            if (state != IDLE) begin
                div_nxt = (div == '0) ? ctrl.N : div - CNT_W'(1);
            end

            // A press before lights-out beats any tick landing in the same cycle.
            if ((state == LIGHTS || state == HOLD) && ctrl.react) begin
                state_nxt = IDLE;
                data_nxt  = 8'h00;
                fs_nxt    = 1'b1;
                rt_nxt    = '1;
                done_nxt  = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (ctrl.trigger) begin
                            state_nxt = LIGHTS;
                            data_nxt  = 8'h00;
                            fs_nxt    = 1'b0;
                            rt_nxt    = '0;
                            div_nxt   = ctrl.N;
                        end
                    end
                    LIGHTS: begin
                        if (tick) begin
                            if (data_q == 8'hFF) begin
                                state_nxt = HOLD;
                                hold_nxt  = lfsr;
                            end else begin
                                data_nxt = {data_q[6:0], 1'b1};
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            hold_nxt = hold_cnt - 7'd1;
                            if (hold_cnt == 7'd1) begin
                                state_nxt = TIMING;
                                data_nxt  = 8'h00;
                                rcnt_nxt  = '0;
                            end
                        end
                    end
                    TIMING: begin
                        if (ctrl.react) begin
                            state_nxt = IDLE;
                            rt_nxt    = rcnt;
                            done_nxt  = 1'b1;
                        end else begin
                            rcnt_nxt = sat_inc(rcnt);
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
            fs_q     <= 1'b0;
            rt_q     <= '0;
            lfsr     <= 7'h01;
            div      <= '0;
            hold_cnt <= 7'd0;
            rcnt     <= '0;
        end else begin
            state    <= state_nxt;
            data_q   <= data_nxt;
            done_q   <= done_nxt;
            fs_q     <= fs_nxt;
            rt_q     <= rt_nxt;
            lfsr     <= lfsr_nxt;
            div      <= div_nxt;
            hold_cnt <= hold_nxt;
            rcnt     <= rcnt_nxt;
        end
    end

    assign ctrl.data_out    = data_q;
    assign ctrl.busy        = (state != IDLE);
    assign ctrl.done        = done_q;
    assign ctrl.false_start = fs_q;
    assign ctrl.react_time  = rt_q;
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed bench for the start sequencer; the lfsr reference gives the hold length H.
module tb_f1_start_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [6:0] m_lfsr;

    f1_start_ctrl_if #(.CNT_W(16)) ifc ();

    f1_start_ctrl #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 7'h01;
        else if (ifc.en) m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    task automatic do_reset;
        rst = 1'b1; ifc.trigger = 1'b0; ifc.react = 1'b0; ifc.en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench just after the edge that accepted the trigger.
    task automatic start_seq(input logic [15:0] n);
        ifc.N = n; ifc.trigger = 1'b1;
        @(negedge clk);
        ifc.trigger = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if ({ifc.data_out, ifc.busy, ifc.done, ifc.false_start} !== 11'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", {ifc.data_out, ifc.busy, ifc.done, ifc.false_start}); end
        n_cmp++; if (ifc.react_time !== 16'h0) begin n_fail++; $display("FAIL reset_react_time got=%h exp=0000", ifc.react_time); end
        n_cmp++; if (dut.lfsr !== 7'h01) begin n_fail++; $display("FAIL reset_lfsr got=%h exp=01", dut.lfsr); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if ({ifc.data_out, ifc.busy, ifc.done} !== 10'h0) begin n_fail++; $display("FAIL idle_quiet cyc=%0d got=%h exp=0", i, {ifc.data_out, ifc.busy, ifc.done}); end
        end
        n_cmp++; if (dut.lfsr !== m_lfsr) begin n_fail++; $display("FAIL idle_lfsr got=%h exp=%h", dut.lfsr, m_lfsr); end
    endtask

    task automatic test_n0;
        logic [6:0] h;
        logic [7:0] exp;
        do_reset;
        start_seq(16'd0);
        n_cmp++; if ({ifc.busy, ifc.data_out} !== 9'h100) begin n_fail++; $display("FAIL n0_start got=%h exp=100", {ifc.busy, ifc.data_out}); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = 8'((1 << k) - 1);
            n_cmp++; if (ifc.data_out !== exp) begin n_fail++; $display("FAIL n0_light k=%0d got=%h exp=%h", k, ifc.data_out, exp); end
        end
        h = m_lfsr;
        @(negedge clk);
        n_cmp++; if ({ifc.busy, ifc.data_out} !== 9'h1FF) begin n_fail++; $display("FAIL n0_hold_entry got=%h exp=1ff", {ifc.busy, ifc.data_out}); end
        repeat (h - 1) @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'hFF) begin n_fail++; $display("FAIL n0_hold_end got=%h exp=ff (H=%0d)", ifc.data_out, h); end
        @(negedge clk);
        n_cmp++; if ({ifc.busy, ifc.data_out} !== 9'h100) begin n_fail++; $display("FAIL n0_lights_out got=%h exp=100 (H=%0d)", {ifc.busy, ifc.data_out}, h); end
        repeat (5) @(negedge clk);
        ifc.react = 1'b1;
        @(negedge clk);
        ifc.react = 1'b0;
        n_cmp++; if ({ifc.done, ifc.false_start, ifc.busy} !== 3'b100) begin n_fail++; $display("FAIL n0_done_flags got=%b exp=100", {ifc.done, ifc.false_start, ifc.busy}); end
        n_cmp++; if (ifc.react_time !== 16'd5) begin n_fail++; $display("FAIL n0_react_time got=%0d exp=5", ifc.react_time); end
        @(negedge clk);
        n_cmp++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL n0_done_single got=%b exp=0", ifc.done); end
    endtask

    task automatic test_n3;
        logic [6:0] h;
        logic [7:0] exp;
        do_reset;
        start_seq(16'd3);
        for (int k = 1; k <= 8; k++) begin
            repeat (3) @(negedge clk);
            exp = 8'((1 << (k - 1)) - 1);
            n_cmp++; if (ifc.data_out !== exp) begin n_fail++; $display("FAIL n3_early k=%0d got=%h exp=%h", k, ifc.data_out, exp); end
            @(negedge clk);
            exp = 8'((1 << k) - 1);
            n_cmp++; if (ifc.data_out !== exp) begin n_fail++; $display("FAIL n3_light k=%0d got=%h exp=%h", k, ifc.data_out, exp); end
        end
        repeat (3) @(negedge clk);
        h = m_lfsr;
        @(negedge clk);
        repeat (4 * h - 1) @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'hFF) begin n_fail++; $display("FAIL n3_hold_end got=%h exp=ff (H=%0d)", ifc.data_out, h); end
        @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h00) begin n_fail++; $display("FAIL n3_lights_out got=%h exp=00 (H=%0d)", ifc.data_out, h); end
        ifc.react = 1'b1;
        @(negedge clk);
        ifc.react = 1'b0;
        n_cmp++; if ({ifc.done, ifc.react_time} !== 17'h10000) begin n_fail++; $display("FAIL n3_react_zero got=%h exp=10000", {ifc.done, ifc.react_time}); end
    endtask

    task automatic test_false_start;
        do_reset;
        start_seq(16'd0);
        repeat (3) @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h07) begin n_fail++; $display("FAIL fs_pre got=%h exp=07", ifc.data_out); end
        ifc.react = 1'b1;
        @(negedge clk);
        ifc.react = 1'b0;
        n_cmp++; if ({ifc.false_start, ifc.done, ifc.busy, ifc.data_out} !== 11'h600) begin n_fail++; $display("FAIL fs_flags got=%h exp=600", {ifc.false_start, ifc.done, ifc.busy, ifc.data_out}); end
        n_cmp++; if (ifc.react_time !== 16'hFFFF) begin n_fail++; $display("FAIL fs_react_time got=%h exp=ffff", ifc.react_time); end
        start_seq(16'd0);
        n_cmp++; if ({ifc.false_start, ifc.react_time} !== 17'h0) begin n_fail++; $display("FAIL fs_cleared got=%h exp=0", {ifc.false_start, ifc.react_time}); end
        ifc.react = 1'b1;
        @(negedge clk);
        ifc.react = 1'b0;
    endtask

    task automatic test_saturation;
        logic [6:0] h;
        do_reset;
        start_seq(16'd0);
        repeat (8) @(negedge clk);
        h = m_lfsr;
        repeat (1 + h) @(negedge clk);
        n_cmp++; if ({ifc.busy, ifc.data_out} !== 9'h100) begin n_fail++; $display("FAIL sat_lights_out got=%h exp=100", {ifc.busy, ifc.data_out}); end
        repeat (70000) @(negedge clk);
        ifc.react = 1'b1;
        @(negedge clk);
        ifc.react = 1'b0;
        n_cmp++; if (ifc.react_time !== 16'hFFFF) begin n_fail++; $display("FAIL sat_react_time got=%h exp=ffff", ifc.react_time); end
        n_cmp++; if ({ifc.done, ifc.false_start} !== 2'b10) begin n_fail++; $display("FAIL sat_flags got=%b exp=10", {ifc.done, ifc.false_start}); end
    endtask

    task automatic test_en_freeze;
        do_reset;
        start_seq(16'd1);
        repeat (6) @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h07) begin n_fail++; $display("FAIL en_pre got=%h exp=07", ifc.data_out); end
        ifc.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (ifc.data_out !== 8'h07) begin n_fail++; $display("FAIL en_frozen cyc=%0d got=%h exp=07", i, ifc.data_out); end
        end
        n_cmp++; if (dut.lfsr !== m_lfsr) begin n_fail++; $display("FAIL en_lfsr got=%h exp=%h", dut.lfsr, m_lfsr); end
        ifc.en = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h07) begin n_fail++; $display("FAIL en_resume_early got=%h exp=07", ifc.data_out); end
        @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h0F) begin n_fail++; $display("FAIL en_resume_step got=%h exp=0f", ifc.data_out); end
        @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h0F) begin n_fail++; $display("FAIL en_spacing_hold got=%h exp=0f", ifc.data_out); end
        @(negedge clk);
        n_cmp++; if (ifc.data_out !== 8'h1F) begin n_fail++; $display("FAIL en_spacing_step got=%h exp=1f", ifc.data_out); end
        ifc.react = 1'b1;
        @(negedge clk);
        ifc.react = 1'b0;
    endtask

    task automatic test_rst_hold;
        do_reset;
        start_seq(16'd0);
        repeat (9) @(negedge clk);
        n_cmp++; if ({ifc.busy, ifc.data_out} !== 9'h1FF) begin n_fail++; $display("FAIL rh_in_hold got=%h exp=1ff", {ifc.busy, ifc.data_out}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({ifc.data_out, ifc.busy, ifc.done, ifc.false_start, ifc.react_time} !== 27'h0) begin n_fail++; $display("FAIL rh_outputs got=%h exp=0", {ifc.data_out, ifc.busy, ifc.done, ifc.false_start, ifc.react_time}); end
        n_cmp++; if (dut.lfsr !== 7'h01) begin n_fail++; $display("FAIL rh_lfsr got=%h exp=01", dut.lfsr); end
        @(negedge clk);
        n_cmp++; if ({ifc.done, ifc.busy} !== 2'b00) begin n_fail++; $display("FAIL rh_no_done got=%b exp=00", {ifc.done, ifc.busy}); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        n_cmp = 0; n_fail = 0;
        ifc.en = 1'b1; ifc.trigger = 1'b0; ifc.react = 1'b0; ifc.N = 16'd0;
        test_reset;
        test_n0;
        test_n3;
        test_false_start;
        test_saturation;
        test_en_freeze;
        test_rst_hold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
